// File: rtl/rfphoenix_pfx_packer.sv
// rfphoenix_pfx_packer
// Pairs each fetched instruction word with an optional trailing postfix word
// (opcode PFX) and presents {ir, pfx, pc} bundles to decode.
//
// Two register stages:
//   _p0 : hold register H, the most recent non-PFX instruction, waiting to
//         learn whether a PFX follows it.
//   _p1 : output register O, which drives out_* directly.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   flush           discard held and pending words (branch redirect)
//   drain           emit the held instruction without waiting for a successor
//   in_valid/ready  fetch-side handshake; in_insn word, in_pc its address
//   out_valid/ready decode-side handshake; out_ir, out_pfx, out_has_pfx, out_pc
//   orphan          one-cycle pulse when a PFX word is dropped
//   orphan_cnt      saturating count of dropped PFX words
module rfphoenix_pfx_packer #(
    parameter int              IW     = 40,
    parameter int              AW     = 32,
    parameter int              OP_LSB = 0,
    parameter int              OP_W   = 6,
    parameter logic [OP_W-1:0] PFX_OP = 6'h3E
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          drain,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_insn,
    input  logic [AW-1:0] in_pc,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_ir,
    output logic [IW-1:0] out_pfx,
    output logic          out_has_pfx,
    output logic [AW-1:0] out_pc,
    output logic          orphan,
    output logic [15:0]   orphan_cnt
);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [IW-1:0] hold_insn_p0;
    logic [AW-1:0] hold_pc_p0;
    logic          vld_p0;

    logic [IW-1:0] ir_p1;
    logic [IW-1:0] pfx_p1;
    logic          has_pfx_p1;
    logic [AW-1:0] pc_p1;
    logic          vld_p1;

    logic          orphan_r;
    logic [15:0]   orphan_cnt_r;

    logic oc;
    logic accept;
    logic is_pfx;
    logic load_pfx;
    logic load_np;
    logic do_drain;
    logic load_o;

    // O can take a new bundle when it is empty or being consumed this cycle.
    // This is the only combinational use of out_ready; out_* come from flops.
    assign oc       = !vld_p1 || out_ready;
    assign in_ready = !flush && !drain && (!vld_p0 || oc);
    assign accept   = in_valid && in_ready;
    assign is_pfx   = (in_insn[OP_LSB +: OP_W] == PFX_OP);

    // A word arriving while H is occupied always pushes H's instruction into O;
    // in_ready already guarantees O has room in that case.
    assign load_pfx = accept && is_pfx && vld_p0;
    assign load_np  = accept && !is_pfx && vld_p0;
    assign do_drain = !flush && drain && vld_p0 && oc;
    assign load_o   = load_pfx || load_np || do_drain;

    // ---- stage p0: hold register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0       <= 1'b0;
            hold_insn_p0 <= '0;
            hold_pc_p0   <= '0;
        end else if (flush) begin
            vld_p0 <= 1'b0;
        end else if (accept && !is_pfx) begin
            hold_insn_p0 <= in_insn;
            hold_pc_p0   <= in_pc;
            vld_p0       <= 1'b1;
        end else if (load_pfx || do_drain) begin
            vld_p0 <= 1'b0;
        end
    end

    // ---- stage p1: output register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            ir_p1      <= '0;
            pfx_p1     <= '0;
            has_pfx_p1 <= 1'b0;
            pc_p1      <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (load_o) begin
            vld_p1     <= 1'b1;
            ir_p1      <= hold_insn_p0;
            pc_p1      <= hold_pc_p0;
            pfx_p1     <= load_pfx ? in_insn : '0;
            has_pfx_p1 <= load_pfx;
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    // A PFX with nothing in H has no instruction to extend and is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            orphan_r     <= 1'b0;
            orphan_cnt_r <= 16'd0;
        end else begin
            orphan_r <= accept && is_pfx && !vld_p0;
            if (accept && is_pfx && !vld_p0)
                orphan_cnt_r <= sat_inc16(orphan_cnt_r);
        end
    end

    assign out_valid   = vld_p1;
    assign out_ir      = ir_p1;
    assign out_pfx     = pfx_p1;
    assign out_has_pfx = has_pfx_p1;
    assign out_pc      = pc_p1;
    assign orphan      = orphan_r;
    assign orphan_cnt  = orphan_cnt_r;

endmodule

// File: tb/tb_rfphoenix_pfx_packer.sv
module tb_rfphoenix_pfx_packer;

    localparam int IW = 40;
    localparam int AW = 32;

    localparam logic [IW-1:0] ADDI = 40'h00_0000_1041;
    localparam logic [IW-1:0] PFXW = 40'h00_0004_8D3E;  // PFX carrying imm 16'h1234
    localparam logic [IW-1:0] ORI  = 40'h00_0000_2082;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush, drain, in_valid, out_ready;
    logic          in_ready, out_valid, out_has_pfx, orphan;
    logic [IW-1:0] in_insn, out_ir, out_pfx;
    logic [AW-1:0] in_pc, out_pc;
    logic [15:0]   orphan_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rfphoenix_pfx_packer dut (
        .clk(clk), .rst(rst), .flush(flush), .drain(drain),
        .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_ir(out_ir),
        .out_pfx(out_pfx), .out_has_pfx(out_has_pfx), .out_pc(out_pc),
        .orphan(orphan), .orphan_cnt(orphan_cnt)
    );

    typedef struct {
        logic          fl, dr, iv;
        logic [IW-1:0] insn;
        logic [AW-1:0] pc;
        logic          ordy;
        logic          e_ird;
        logic          e_ov;
        logic [IW-1:0] e_ir;
        logic [IW-1:0] e_pfx;
        logic          e_has;
        logic [AW-1:0] e_pc;
        logic          e_orph;
        logic [15:0]   e_cnt;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic v(input logic fl, input logic dr, input logic iv,
                     input logic [IW-1:0] insn, input logic [AW-1:0] pc, input logic ordy,
                     input logic e_ird, input logic e_ov, input logic [IW-1:0] e_ir,
                     input logic [IW-1:0] e_pfx, input logic e_has, input logic [AW-1:0] e_pc,
                     input logic e_orph, input logic [15:0] e_cnt);
        vec_t r;
        r.fl = fl; r.dr = dr; r.iv = iv; r.insn = insn; r.pc = pc; r.ordy = ordy;
        r.e_ird = e_ird; r.e_ov = e_ov; r.e_ir = e_ir; r.e_pfx = e_pfx;
        r.e_has = e_has; r.e_pc = e_pc; r.e_orph = e_orph; r.e_cnt = e_cnt;
        vq.push_back(r);
    endtask

    function automatic logic [IW-1:0] wn(input int i);
        logic [IW-1:0] w;
        w = {26'h2AB0000, 8'(i), 6'h05};
        return w;
    endfunction

    task automatic drive(input logic fl, input logic dr, input logic iv,
                         input logic [IW-1:0] insn, input logic [AW-1:0] pc, input logic ordy);
        @(negedge clk);
        flush = fl; drain = dr; in_valid = iv; in_insn = insn; in_pc = pc; out_ready = ordy;
    endtask

    initial begin
        // ---- stimulus table ----
        // Instruction + PFX, then ORI released by drain.
        v(0,0,1,ADDI,32'h100,1, 1, 0,'0,'0,0,'0, 0,16'd0);
        v(0,0,1,PFXW,32'h105,1, 1, 1,ADDI,PFXW,1,32'h100, 0,16'd0);
        v(0,0,1,ORI ,32'h10A,1, 1, 0,'0,'0,0,'0, 0,16'd0);
        v(0,1,0,'0  ,32'h0  ,1, 0, 1,ORI,'0,0,32'h10A, 0,16'd0);
        v(0,0,0,'0  ,32'h0  ,1, 1, 0,'0,'0,0,'0, 0,16'd0);
        // Eight back-to-back non-PFX words: seven bundles, eighth held.
        v(0,0,1,wn(0),32'h200,1, 1, 0,'0,'0,0,'0, 0,16'd0);
        for (int i = 1; i < 8; i++)
            v(0,0,1,wn(i),32'h200 + 32'(4*i),1, 1, 1,wn(i-1),'0,0,32'h200 + 32'(4*(i-1)), 0,16'd0);
        v(0,0,0,'0,32'h0,1, 1, 0,'0,'0,0,'0, 0,16'd0);
        v(0,1,0,'0,32'h0,1, 0, 1,wn(7),'0,0,32'h21C, 0,16'd0);
        v(0,0,0,'0,32'h0,1, 1, 0,'0,'0,0,'0, 0,16'd0);
        // Orphans: PFX with empty H, then a second PFX after an attached one.
        v(0,0,1,PFXW,32'h300,1, 1, 0,'0,'0,0,'0, 1,16'd1);
        v(0,0,1,ADDI,32'h304,1, 1, 0,'0,'0,0,'0, 0,16'd1);
        v(0,0,1,PFXW,32'h308,1, 1, 1,ADDI,PFXW,1,32'h304, 0,16'd1);
        v(0,0,1,PFXW,32'h30C,1, 1, 0,'0,'0,0,'0, 1,16'd2);
        v(0,0,0,'0  ,32'h0  ,1, 1, 0,'0,'0,0,'0, 0,16'd2);
        // Backpressure with O and H full.
        v(0,0,1,ADDI,32'h400,0, 1, 0,'0,'0,0,'0, 0,16'd2);
        v(0,0,1,ORI ,32'h404,0, 1, 1,ADDI,'0,0,32'h400, 0,16'd2);
        for (int i = 0; i < 5; i++)
            v(0,0,1,wn(9),32'h408,0, 0, 1,ADDI,'0,0,32'h400, 0,16'd2);
        v(0,0,1,wn(9),32'h408,1, 1, 1,ORI,'0,0,32'h404, 0,16'd2);
        v(0,0,0,'0,32'h0,1, 1, 0,'0,'0,0,'0, 0,16'd2);
        v(0,1,0,'0,32'h0,1, 0, 1,wn(9),'0,0,32'h408, 0,16'd2);
        v(0,0,0,'0,32'h0,1, 1, 0,'0,'0,0,'0, 0,16'd2);
        // Flush with hv=1, ov=1 and a word offered.
        v(0,0,1,wn(20),32'h500,1, 1, 0,'0,'0,0,'0, 0,16'd2);
        v(0,0,1,wn(21),32'h504,0, 1, 1,wn(20),'0,0,32'h500, 0,16'd2);
        v(1,0,1,wn(22),32'h508,0, 0, 0,'0,'0,0,'0, 0,16'd2);
        v(0,1,0,'0,32'h0,1, 0, 0,'0,'0,0,'0, 0,16'd2);
        v(0,0,1,PFXW,32'h50C,1, 1, 0,'0,'0,0,'0, 1,16'd3);
        v(0,0,1,wn(23),32'h510,1, 1, 0,'0,'0,0,'0, 0,16'd3);
        v(0,0,1,wn(24),32'h514,1, 1, 1,wn(23),'0,0,32'h510, 0,16'd3);
        v(0,0,0,'0,32'h0,1, 1, 0,'0,'0,0,'0, 0,16'd3);

        // ---- reset state ----
        rst = 1'b1; flush = 0; drain = 0; in_valid = 0; in_insn = '0; in_pc = '0; out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_ir", 64'(out_ir), 64'd0);
        chk("rst_orphan_cnt", 64'(orphan_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rst_in_ready", 64'(in_ready), 64'd1);

        // ---- table ----
        for (int k = 0; k < vq.size(); k++) begin
            drive(vq[k].fl, vq[k].dr, vq[k].iv, vq[k].insn, vq[k].pc, vq[k].ordy);
            #1 chk($sformatf("v%0d_in_ready", k), 64'(in_ready), 64'(vq[k].e_ird));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", k), 64'(out_valid), 64'(vq[k].e_ov));
            if (vq[k].e_ov) begin
                chk($sformatf("v%0d_out_ir", k), 64'(out_ir), 64'(vq[k].e_ir));
                chk($sformatf("v%0d_out_pfx", k), 64'(out_pfx), 64'(vq[k].e_pfx));
                chk($sformatf("v%0d_out_has_pfx", k), 64'(out_has_pfx), 64'(vq[k].e_has));
                chk($sformatf("v%0d_out_pc", k), 64'(out_pc), 64'(vq[k].e_pc));
            end
            chk($sformatf("v%0d_orphan", k), 64'(orphan), 64'(vq[k].e_orph));
            chk($sformatf("v%0d_orphan_cnt", k), 64'(orphan_cnt), 64'(vq[k].e_cnt));
        end

        // ---- asynchronous reset mid-stream ----
        drive(0,0,1,wn(30),32'h600,1);
        drive(0,0,1,wn(31),32'h604,1);
        @(posedge clk);
        #1 chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        in_valid = 0;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_out_ir", 64'(out_ir), 64'd0);
        chk("async_rst_out_pc", 64'(out_pc), 64'd0);
        chk("async_rst_orphan_cnt", 64'(orphan_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst_drain_empty", 64'(out_valid), 64'd0);
        drive(0,1,0,'0,32'h0,1);
        @(posedge clk);
        #1 chk("post_rst_h_empty", 64'(out_valid), 64'd0);

        // ---- orphan_cnt saturation ----
        drive(0,0,1,PFXW,32'h700,1);
        repeat (65535) @(posedge clk);
        #1;
        chk("sat_reach_ffff", 64'(orphan_cnt), 64'hFFFF);
        @(posedge clk);
        #1;
        chk("sat_hold_ffff", 64'(orphan_cnt), 64'hFFFF);
        chk("sat_orphan_pulse", 64'(orphan), 64'd1);
        chk("sat_no_bundle", 64'(out_valid), 64'd0);
        drive(0,0,0,'0,32'h0,1);
        @(posedge clk);
        #1;
        chk("sat_orphan_low", 64'(orphan), 64'd0);
        chk("sat_final_cnt", 64'(orphan_cnt), 64'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
